// File: rtl/etapa_mem_sized_pkg.sv
// -----------------------------------------------------------------------------
// etapa_mem_pkg
// Shared definitions for the sized MEM pipeline stage:
//   - access size encodings carried on i_MEM_size
//   - FSM state encoding for the multi-cycle memory access sequencer
//   - helper functions for alignment checks, byte-lane enables,
//     store-data lane replication and load-data extraction/extension.
// Byte lanes are little-endian: byte k of a word lives at address base+k.
// -----------------------------------------------------------------------------
package etapa_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // The reserved size code 2'b11 falls into the default arms below, so it
  // behaves exactly like a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = addr_lo[0];
      default:  is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: lane_enable = 4'b0001 << addr_lo;
      MEM_HALF: lane_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  lane_enable = 4'b1111;
    endcase
  endfunction

  // Replicating the low byte/half across the word puts the data on every
  // lane it could land on; the byte enables then pick the right one(s).
  function automatic logic [31:0] lane_store_data(input logic [1:0]  size,
                                                  input logic [31:0] data);
    case (size)
      MEM_BYTE: lane_store_data = {4{data[7:0]}};
      MEM_HALF: lane_store_data = {2{data[15:0]}};
      default:  lane_store_data = data;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addr_lo,
                                              input logic        zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*addr_lo +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: extend_load = {{24{b[7] & ~zero_ext}}, b};
      MEM_HALF: extend_load = {{16{h[15] & ~zero_ext}}, h};
      default:  extend_load = word;
    endcase
  endfunction

endpackage

// File: rtl/etapa_mem_sized_if.sv
// -----------------------------------------------------------------------------
// etapa_mem_sized_if
// Bundles the EX/MEM-side inputs and the MEM/WB-side outputs of the sized MEM
// stage. Signal names keep the i_/o_ prefixes of the stage's port list so they
// read the same as the rest of the datapath.
//   master : the pipeline around the stage (drives i_*, observes o_*)
//   slave  : the MEM stage itself (observes i_*, drives o_*)
// -----------------------------------------------------------------------------
interface etapa_mem_sized_if;

  logic [4:0]  i_write_reg;
  logic [31:0] i_data_to_write_in_MEM;
  logic [31:0] i_ALU_result;
  logic        i_WB_write;
  logic        i_WB_mem_to_reg;
  logic        i_MEM_read;
  logic        i_MEM_write;
  logic [1:0]  i_MEM_size;
  logic        i_MEM_unsigned;

  logic        o_stall;
  logic        o_misaligned;
  logic        o_WB_write;
  logic        o_WB_mem_to_reg;
  logic [31:0] o_ALU_result;
  logic [31:0] o_read_data;
  logic [4:0]  o_write_reg;

  modport master (
    output i_write_reg, i_data_to_write_in_MEM, i_ALU_result, i_WB_write,
           i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_size,
           i_MEM_unsigned,
    input  o_stall, o_misaligned, o_WB_write, o_WB_mem_to_reg, o_ALU_result,
           o_read_data, o_write_reg
  );

  modport slave (
    input  i_write_reg, i_data_to_write_in_MEM, i_ALU_result, i_WB_write,
           i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_size,
           i_MEM_unsigned,
    output o_stall, o_misaligned, o_WB_write, o_WB_mem_to_reg, o_ALU_result,
           o_read_data, o_write_reg
  );

endinterface

// File: rtl/etapa_mem_sized_ram_byte_lanes.sv
// -----------------------------------------------------------------------------
// ram_byte_lanes
// Data memory of 2^ADDR_WIDTH bytes organised as four byte-wide lanes.
// Lane k holds byte k of every word (little-endian).
//   i_clk        write clock, rising edge
//   i_we         per-lane byte enables, write happens on the rising edge
//   i_word_addr  word index (byte address without its two low bits)
//   i_wdata      write data, already placed on the target lanes
//   o_rdata      asynchronous read of the whole word at i_word_addr
// Contents are deliberately not reset.
// -----------------------------------------------------------------------------
module ram_byte_lanes #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-3:0] i_word_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [WORDS];

    always_ff @(posedge i_clk) begin
      if (i_we[g]) begin
        lane_mem[i_word_addr] <= i_wdata[8*g +: 8];
      end
    end

    assign o_rdata[8*g +: 8] = lane_mem[i_word_addr];
  end

endmodule

// File: rtl/etapa_mem_sized.sv
// -----------------------------------------------------------------------------
// etapa_mem_sized
// MEM pipeline stage of the MIPS datapath with sized (byte/half/word) loads
// and stores, sign/zero extension, misalignment detection and a configurable
// data-memory latency.
//   i_clk    rising-edge clock
//   i_reset  asynchronous active-high reset (clears outputs, FSM, counter)
//   bus      etapa_mem_sized_if.slave:
//              inputs  : write reg, store data, ALU result/address, WB
//                        controls, MEM read/write/size/unsigned
//              outputs : o_stall (combinational), o_misaligned and the
//                        registered MEM/WB boundary (WB controls, ALU result,
//                        extended read data, destination register)
// With MEM_LATENCY = N > 0 every aligned memory access holds the pipeline for
// N cycles and completes on the (N+1)-th edge; with N = 0 the stage never
// stalls.
// -----------------------------------------------------------------------------
module etapa_mem_sized
  import etapa_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 0
) (
  input logic             i_clk,
  input logic             i_reset,
  etapa_mem_sized_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = (MEM_LATENCY == 0) ? 4'd0
                                                      : 4'(MEM_LATENCY - 1);

  mem_state_t              state;
  logic [3:0]              cnt;

  logic [ADDR_WIDTH-1:0]   addr;
  logic                    misaligned;
  logic                    mem_req;
  logic                    is_load;
  logic                    stall;
  logic [3:0]              lane_we;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [DATA_WIDTH-1:0]   load_data;

  assign addr       = bus.i_ALU_result[ADDR_WIDTH-1:0];
  assign misaligned = (bus.i_MEM_read | bus.i_MEM_write)
                    & is_misaligned(bus.i_MEM_size, addr[1:0]);
  assign mem_req    = (bus.i_MEM_read | bus.i_MEM_write) & ~misaligned;
  // A simultaneous read+write is a store, so it never produces load data.
  assign is_load    = bus.i_MEM_read & ~bus.i_MEM_write & ~misaligned;

  // Only the first cycle of an access (IDLE) and the counting WAIT cycles
  // stall; the WAIT cycle with cnt == 0 is the completion cycle.
  if (MEM_LATENCY == 0) begin : g_no_latency
    assign stall = 1'b0;
  end else begin : g_latency
    assign stall = (state == ST_IDLE) ? mem_req : (cnt != 4'd0);
  end

  assign bus.o_stall = stall;

  // The write is gated by the stall so it lands on the completion edge only,
  // and by the reset so a store pending while reset is held is dropped.
  assign lane_we   = (bus.i_MEM_write && !misaligned && !stall && !i_reset)
                   ? lane_enable(bus.i_MEM_size, addr[1:0]) : 4'b0000;
  assign ram_wdata = lane_store_data(bus.i_MEM_size, bus.i_data_to_write_in_MEM);
  assign load_data = extend_load(ram_rdata, bus.i_MEM_size, addr[1:0],
                                 bus.i_MEM_unsigned);

  ram_byte_lanes #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk       (i_clk),
    .i_we        (lane_we),
    .i_word_addr (addr[ADDR_WIDTH-1:2]),
    .i_wdata     (ram_wdata),
    .o_rdata     (ram_rdata)
  );

  // Sequencer plus the MEM/WB boundary registers. A stalled edge captures a
  // bubble (no register write, no misaligned flag) and leaves the rest of
  // the boundary untouched.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state               <= ST_IDLE;
      cnt                 <= 4'd0;
      bus.o_misaligned    <= 1'b0;
      bus.o_WB_write      <= 1'b0;
      bus.o_WB_mem_to_reg <= 1'b0;
      bus.o_ALU_result    <= '0;
      bus.o_read_data     <= '0;
      bus.o_write_reg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stall) begin
            state <= ST_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase

      if (stall) begin
        bus.o_WB_write   <= 1'b0;
        bus.o_misaligned <= 1'b0;
      end else begin
        bus.o_misaligned    <= misaligned;
        bus.o_WB_write      <= bus.i_WB_write & ~misaligned;
        bus.o_WB_mem_to_reg <= bus.i_WB_mem_to_reg;
        bus.o_ALU_result    <= bus.i_ALU_result;
        bus.o_write_reg     <= bus.i_write_reg;
        bus.o_read_data     <= is_load ? load_data : '0;
      end
    end
  end

endmodule
